// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front end: default widths, NOP encoding
// and the queue entry layout.
package fetch_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer: writes FETCH_W entries at once, retires
// 0..FETCH_W from the head, and exposes the oldest FETCH_W entries as a window.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int FETCH_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush_i,
  input  logic                           enq_i,
  input  logic [FETCH_W*DATA_W-1:0]      enqData_i,
  input  logic [ADDR_W-1:0]              enqPc_i,
  input  logic [$clog2(FETCH_W+1)-1:0]   deqCount_i,
  output logic [FETCH_W*DATA_W-1:0]      winData_o,
  output logic [FETCH_W*ADDR_W-1:0]      winPc_o,
  output logic [FETCH_W-1:0]             winValid_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] memData_q [DEPTH];
  logic [ADDR_W-1:0] memPc_q   [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(DEPTH)) sum = sum - 32'(DEPTH);
    return sum[PTR_W-1:0];
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      head_d = wrapIdx(head_q, 32'(deqCount_i));
      if (enq_i) tail_d = wrapIdx(tail_q, FETCH_W);
      count_d = count_q + (enq_i ? CNT_W'(FETCH_W) : '0) - CNT_W'(deqCount_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_i && !flush_i) begin
      for (int i = 0; i < FETCH_W; i++) begin
        memData_q[wrapIdx(tail_q, i)] <= enqData_i[i*DATA_W +: DATA_W];
        memPc_q[wrapIdx(tail_q, i)]   <= enqPc_i + ADDR_W'(i);
      end
    end
  end

  // Lanes beyond the occupied count present a NOP with zero PC.
  always_comb begin
    winData_o  = '0;
    winPc_o    = '0;
    winValid_o = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      winData_o[i*DATA_W +: DATA_W] = DATA_W'(NOP_INSTR);
      if (CNT_W'(i) < count_q) begin
        winData_o[i*DATA_W +: DATA_W] = memData_q[wrapIdx(head_q, i)];
        winPc_o[i*ADDR_W +: ADDR_W]   = memPc_q[wrapIdx(head_q, i)];
        winValid_o[i]                 = 1'b1;
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC, fetch credit, in-flight tracking and the decoupling queue.
// Defining FETCH_PERF_EN adds saturating flush/stall/empty counters and ports.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int FETCH_W     = 2,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 stall,
  input  logic [$clog2(FETCH_W+1)-1:0]         issue_count,
  input  logic                                 is_branch_taken,
  input  logic [ADDR_W-1:0]                    branch_target,
  output logic                                 imem_req,
  output logic [ADDR_W-1:0]                    imem_addr,
  input  logic [FETCH_W*DATA_W-1:0]            imem_rdata,
  output logic [FETCH_W*DATA_W-1:0]            instr,
  output logic [FETCH_W*ADDR_W-1:0]            instr_pc,
  output logic [FETCH_W-1:0]                   instr_valid,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]     queue_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                          perf_flush_cnt,
  output logic [31:0]                          perf_stall_cnt,
  output logic [31:0]                          perf_empty_cnt
`endif
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH+1);
  localparam int IC_W  = $clog2(FETCH_W+1);
  localparam int SUM_W = CNT_W + 2;

  logic [ADDR_W-1:0] pc_q, pc_d, reqAddr_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  count;
  logic [SUM_W-1:0]  committed;
  logic              creditOk, enq;
  logic [IC_W-1:0]   deqCount;

  // Credit counts queued plus in-flight words; this cycle's dequeue is ignored.
  always_comb begin
    committed = SUM_W'(count) + SUM_W'(FETCH_W) + (inflight_q ? SUM_W'(FETCH_W) : '0);
    creditOk  = (committed <= SUM_W'(QUEUE_DEPTH));
  end

  assign imem_req  = !reset && !is_branch_taken && creditOk;
  assign imem_addr = pc_q;
  assign enq       = inflight_q && !is_branch_taken;

  always_comb begin
    deqCount = '0;
    if (!stall && !is_branch_taken)
      deqCount = (CNT_W'(issue_count) > count) ? IC_W'(count) : issue_count;
  end

  always_comb begin
    pc_d = pc_q;
    if (is_branch_taken)  pc_d = branch_target;
    else if (imem_req)    pc_d = pc_q + ADDR_W'(FETCH_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      reqAddr_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= imem_req;
      if (imem_req) reqAddr_q <= pc_q;
    end
  end

  fetch_queue #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .FETCH_W (FETCH_W),
    .DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (is_branch_taken),
    .enq_i      (enq),
    .enqData_i  (imem_rdata),
    .enqPc_i    (reqAddr_q),
    .deqCount_i (deqCount),
    .winData_o  (instr),
    .winPc_o    (instr_pc),
    .winValid_o (instr_valid),
    .count_o    (count)
  );

  assign queue_count = count;

`ifdef FETCH_PERF_EN
  logic [31:0] flushCnt_q, stallCnt_q, emptyCnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flushCnt_q <= '0;
      stallCnt_q <= '0;
      emptyCnt_q <= '0;
    end else begin
      if (is_branch_taken && flushCnt_q != '1)                    flushCnt_q <= flushCnt_q + 1'b1;
      if (stall && count != '0 && stallCnt_q != '1)               stallCnt_q <= stallCnt_q + 1'b1;
      if (count == '0 && !is_branch_taken && emptyCnt_q != '1)    emptyCnt_q <= emptyCnt_q + 1'b1;
    end
  end

  assign perf_flush_cnt = flushCnt_q;
  assign perf_stall_cnt = stallCnt_q;
  assign perf_empty_cnt = emptyCnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int FW = 2;
  localparam int QD = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic [1:0]        issue_count = '0;
  logic              is_branch_taken = 1'b0;
  logic [AW-1:0]     branch_target = '0;
  logic              imem_req;
  logic [AW-1:0]     imem_addr;
  logic [FW*DW-1:0]  imem_rdata = '0;
  logic [FW*DW-1:0]  instr;
  logic [FW*AW-1:0]  instr_pc;
  logic [FW-1:0]     instr_valid;
  logic [3:0]        queue_count;

  int testsRun = 0;
  int testsFailed = 0;

  fetch_entry_t  mQueue[$];
  logic [AW-1:0] mPc = '0;
  logic [AW-1:0] mInAddr = '0;
  bit            mInflight = 1'b0;

  fetch_queue_unit #(
    .DATA_W (DW), .ADDR_W (AW), .FETCH_W (FW), .QUEUE_DEPTH (QD)
  ) dut (
    .clk (clk), .reset (reset), .stall (stall), .issue_count (issue_count),
    .is_branch_taken (is_branch_taken), .branch_target (branch_target),
    .imem_req (imem_req), .imem_addr (imem_addr), .imem_rdata (imem_rdata),
    .instr (instr), .instr_pc (instr_pc), .instr_valid (instr_valid),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    return 16'h1000 + a;
  endfunction

  // Synchronous instruction memory; garbage when not requested.
  always @(posedge clk) begin
    for (int i = 0; i < FW; i++)
      imem_rdata[i*DW +: DW] <= imem_req ? memWord(imem_addr + AW'(i)) : DW'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit modelReq(input logic br);
    int freeSlots;
    freeSlots = QD - mQueue.size() - (mInflight ? FW : 0);
    return !br && (freeSlots >= FW);
  endfunction

  task automatic modelStep(input logic st, input logic [1:0] ic, input logic br, input logic [AW-1:0] tgt);
    int n;
    bit req;
    fetch_entry_t e;
    req = modelReq(br);
    if (br) begin
      mQueue.delete();
      mPc = tgt;
      mInflight = 1'b0;
    end else begin
      n = (int'(ic) < mQueue.size()) ? int'(ic) : mQueue.size();
      if (st) n = 0;
      repeat (n) void'(mQueue.pop_front());
      if (mInflight) begin
        for (int i = 0; i < FW; i++) begin
          e.pc = mInAddr + AW'(i);
          e.data = memWord(e.pc);
          mQueue.push_back(e);
        end
      end
      if (req) begin
        mInAddr = mPc;
        mPc = mPc + AW'(FW);
      end
      mInflight = req;
    end
  endtask

  task automatic modelReset();
    mQueue.delete();
    mPc = '0;
    mInAddr = '0;
    mInflight = 1'b0;
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] ic, input logic br, input logic [AW-1:0] tgt);
    logic [FW*DW-1:0] eInstr;
    logic [FW*AW-1:0] ePc;
    logic [FW-1:0]    eValid;
    bit               eReq;
    @(negedge clk);
    reset = 1'b0;
    stall = st;
    issue_count = ic;
    is_branch_taken = br;
    branch_target = tgt;
    #1;
    eInstr = '0;
    ePc = '0;
    eValid = '0;
    for (int i = 0; i < FW; i++) begin
      if (i < mQueue.size()) begin
        eInstr[i*DW +: DW] = mQueue[i].data;
        ePc[i*AW +: AW] = mQueue[i].pc;
        eValid[i] = 1'b1;
      end
    end
    eReq = modelReq(br);
    checkOutput("queue_count", 64'(queue_count), 64'(mQueue.size()));
    checkOutput("instr", 64'(instr), 64'(eInstr));
    checkOutput("instr_pc", 64'(instr_pc), 64'(ePc));
    checkOutput("instr_valid", 64'(instr_valid), 64'(eValid));
    checkOutput("imem_req", 64'(imem_req), 64'(eReq));
    if (eReq) checkOutput("imem_addr", 64'(imem_addr), 64'(mPc));
    @(posedge clk);
    modelStep(st, ic, br, tgt);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_imem_req"}, 64'(imem_req), 64'd0);
    checkOutput({tag, "_instr"}, 64'(instr), 64'd0);
    checkOutput({tag, "_instr_pc"}, 64'(instr_pc), 64'd0);
    checkOutput({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
    checkOutput({tag, "_queue_count"}, 64'(queue_count), 64'd0);
  endtask

  // Reset stays asserted on return; the next applyStimulus releases it.
  task automatic doReset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    issue_count = '0;
    is_branch_taken = 1'b0;
    branch_target = '0;
    #1;
    checkResetState("rst_now");
    modelReset();
    repeat (cycles) begin
      @(negedge clk);
      #1;
      checkResetState("rst_hold");
    end
  endtask

  task automatic randomCycle();
    logic [AW-1:0] tgt;
    logic st, br;
    st = ($urandom_range(3) == 0);
    br = ($urandom_range(15) == 0);
    tgt = ($urandom_range(3) == 0) ? AW'(16'hFFFC + $urandom_range(3)) : AW'($urandom);
    applyStimulus(st, 2'($urandom_range(2)), br, tgt);
  endtask

  initial begin
    doReset(3);
    repeat (6) applyStimulus(1'b0, 2'd2, 1'b0, '0);
    repeat (5) applyStimulus(1'b1, 2'd2, 1'b0, '0);
    repeat (20) applyStimulus(1'b0, 2'd1, 1'b0, '0);
    repeat (4) applyStimulus(1'b0, 2'd2, 1'b0, '0);
    applyStimulus(1'b0, 2'd2, 1'b1, 16'h0040);
    repeat (8) applyStimulus(1'b0, 2'd2, 1'b0, '0);
    applyStimulus(1'b0, 2'd2, 1'b1, 16'hFFFE);
    repeat (8) applyStimulus(1'b0, 2'd2, 1'b0, '0);
    repeat (1500) randomCycle();
    repeat (3) applyStimulus(1'b0, 2'd2, 1'b0, '0);
    doReset(2);
    repeat (6) applyStimulus(1'b0, 2'd2, 1'b0, '0);
    repeat (200) randomCycle();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
